// File: rtl/axi4_lite_read_arbiter.sv
// Two-master AXI4-Lite read arbiter: m0 (fetch) and m1 (load) share one slave
// read port. One read in flight; the owner holds the grant from AR through R.
// Ties are broken round-robin against the last completed owner.
module axi4_lite_read_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_ar_addr,
  input  logic              m0_ar_valid,
  input  logic [2:0]        m0_ar_prot,
  output logic              m0_ar_ready,
  output logic [DATA_W-1:0] m0_r_data,
  output logic [1:0]        m0_r_resp,
  output logic              m0_r_valid,
  input  logic              m0_r_ready,
  input  logic [ADDR_W-1:0] m1_ar_addr,
  input  logic              m1_ar_valid,
  input  logic [2:0]        m1_ar_prot,
  output logic              m1_ar_ready,
  output logic [DATA_W-1:0] m1_r_data,
  output logic [1:0]        m1_r_resp,
  output logic              m1_r_valid,
  input  logic              m1_r_ready,
  output logic [ADDR_W-1:0] s_ar_addr,
  output logic              s_ar_valid,
  output logic [2:0]        s_ar_prot,
  input  logic              s_ar_ready,
  input  logic [DATA_W-1:0] s_r_data,
  input  logic [1:0]        s_r_resp,
  input  logic              s_r_valid,
  output logic              s_r_ready,
  output logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state, state_nxt;
  logic [1:0] grant_q, grant_nxt;
  logic       last_q, last_nxt;   // 0 = m0 finished last, 1 = m1 finished last

  logic in_addr, in_data;
  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  assign busy  = (state != IDLE);
  assign grant = grant_q;

  // State, grant and round-robin history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;   // m0 wins the first tie after reset
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
    end
  end

  // Combinational routing from the registered grant; nothing is buffered
  always_comb begin
    s_ar_valid  = 1'b0;
    s_ar_addr   = '0;
    s_ar_prot   = 3'b000;
    s_r_ready   = 1'b0;
    m0_ar_ready = 1'b0;
    m1_ar_ready = 1'b0;
    m0_r_valid  = 1'b0;
    m1_r_valid  = 1'b0;
    m0_r_data   = '0;
    m1_r_data   = '0;
    m0_r_resp   = 2'b00;
    m1_r_resp   = 2'b00;
    if (in_addr) begin
      if (grant_q[0]) begin
        s_ar_valid  = m0_ar_valid;
        s_ar_addr   = m0_ar_addr;
        s_ar_prot   = m0_ar_prot;
        m0_ar_ready = s_ar_ready;
      end else if (grant_q[1]) begin
        s_ar_valid  = m1_ar_valid;
        s_ar_addr   = m1_ar_addr;
        s_ar_prot   = m1_ar_prot;
        m1_ar_ready = s_ar_ready;
      end
    end
    if (in_data) begin
      if (grant_q[0]) begin
        s_r_ready  = m0_r_ready;
        m0_r_valid = s_r_valid;
        m0_r_data  = s_r_data;
        m0_r_resp  = s_r_resp;
      end else if (grant_q[1]) begin
        s_r_ready  = m1_r_ready;
        m1_r_valid = s_r_valid;
        m1_r_data  = s_r_data;
        m1_r_resp  = s_r_resp;
      end
    end
  end

  // Next-state: pick an owner in IDLE, then wait for the AR and R handshakes
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    last_nxt  = last_q;
    unique case (state)
      IDLE: begin
        if (m0_ar_valid && m1_ar_valid) begin
          grant_nxt = last_q ? 2'b01 : 2'b10;
          state_nxt = ADDR;
        end else if (m0_ar_valid) begin
          grant_nxt = 2'b01;
          state_nxt = ADDR;
        end else if (m1_ar_valid) begin
          grant_nxt = 2'b10;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (s_ar_valid && s_ar_ready) state_nxt = DATA;
      end
      DATA: begin
        // Any response code, error or not, closes the transaction
        if (s_r_valid && s_r_ready) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
          last_nxt  = grant_q[1];
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

endmodule

// File: doc/axi4_lite_read_arbiter.md
# axi4_lite_read_arbiter

- Shares one AXI4-Lite slave read port between two read masters: m0 = IFU fetch master, m1 = MEM load master.
- Each read transaction holds the grant from AR handshake through R handshake; only one read is outstanding at a time.
- When both masters request, the grant alternates round-robin.
- Sits between the two AXI4_READ_MASTER instances and the slave side of the bus; the write path bypasses this block.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width

Ports (clock and reset first):
- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- m0_ar_addr / m1_ar_addr  in  ADDR_W  read address from the master
- m0_ar_valid / m1_ar_valid  in  1  read request
- m0_ar_prot / m1_ar_prot  in  3  protection bits; forwarded unchanged
- m0_ar_ready / m1_ar_ready  out  1  address accepted
- m0_r_data / m1_r_data  out  DATA_W  read data
- m0_r_resp / m1_r_resp  out  2  read response
- m0_r_valid / m1_r_valid  out  1  read data valid
- m0_r_ready / m1_r_ready  in  1  master ready for data
- s_ar_addr  out  ADDR_W; s_ar_valid  out  1; s_ar_prot  out  3; s_ar_ready  in  1
- s_r_data  in  DATA_W; s_r_resp  in  2; s_r_valid  in  1; s_r_ready  out  1
- busy  out  1  a transaction is in progress (state != IDLE)
- grant  out  2  one-hot owner: bit0 = m0, bit1 = m1; 00 in IDLE

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If no mX_ar_valid is high, stay in IDLE.
  - If only one master requests, grant that master.
  - If both request, grant the master that is not last_grant.
  - The grant is registered on the clock edge; next state is ADDR.
- ADDR: drive s_ar_addr, s_ar_prot and s_ar_valid from the granted master, and return s_ar_ready to it. On s_ar_valid && s_ar_ready, go to DATA.
- DATA: drive s_r_data, s_r_resp and s_r_valid to the granted master, and drive s_r_ready from its r_ready. On s_r_valid && s_r_ready, go to IDLE and set last_grant to the current owner.
- Non-granted master, in every state: ar_ready = 0, r_valid = 0, r_data = 0, r_resp = 0.
- Slave outputs outside their phase:
  - s_ar_valid, s_ar_addr and s_ar_prot are 0 when the state is not ADDR.
  - s_r_ready is 0 when the state is not DATA.
- Routing in ADDR and DATA is combinational from the registered grant; there is no data buffering.
- r_resp is passed through unchanged, SLVERR/DECERR included. An error response ends the transaction like OKAY.
- No abort path: a granted master that drops ar_valid in ADDR keeps the grant until a handshake completes.

## Timing
- Reset values:
  - state = IDLE, grant = 00, busy = 0, last_grant = m1, so m0 wins the first tie.
  - All ready/valid outputs 0; all data/addr/resp outputs 0.
- Request to slave: mX_ar_valid high in cycle N (state IDLE) gives s_ar_valid high in cycle N+1.
- Zero-wait slave: s_ar_ready = 1 in N+1 and s_r_valid = 1 in N+2 complete the read with mX_r_valid in N+2 and IDLE in N+3. Minimum 3 cycles per transaction; back-to-back requests can be granted every 3 cycles.
- A request that arrives while busy waits. It is evaluated in the first IDLE cycle.
- Simultaneous requests in IDLE: the round-robin rule applies in the same cycle.
- Sustained contention strictly alternates m0, m1, m0, …; neither master waits more than one transaction.
- The AR and R handshakes may stall for any number of cycles; state and grant are held stable throughout.
- Reset mid-transaction (ADDR or DATA): next cycle returns to reset values; the in-flight transaction is dropped.

## Test plan
- Single m0 read:
  - Stimulus: m0_ar_addr = 0x8000_0000, slave returns 0x0000_0013_0000_0297 with OKAY and zero wait.
  - Required: s_ar_valid at N+1, m0_r_data = that value at N+2, busy back to 0 at N+3, m1 outputs stay 0 throughout.
- Simultaneous requests from reset:
  - Stimulus: m0 and m1 both assert ar_valid at cycle 0 and hold it.
  - Required: m0 is served first (grant = 01), then m1 (grant = 10).
  - Continued: repeated simultaneous requests alternate 01, 10, 01.
- Slave stalls:
  - Stimulus: s_ar_ready held low for 4 cycles, then s_r_valid delayed 5 cycles.
  - Required: grant, s_ar_addr and busy stay constant; exactly one mX_r_valid handshake occurs.
- Error response:
  - Stimulus: m1 reads 0x0000_0000 and the slave answers r_resp = 2'b10.
  - Required: m1_r_resp = 2'b10, the FSM returns to IDLE, and the next m0 request is granted normally.
- Master back-pressure:
  - Stimulus: m1_r_ready held low for 3 cycles while s_r_valid = 1.
  - Required: s_r_ready = 0 for those cycles; data is delivered on the first cycle m1_r_ready = 1.
- Reset in DATA:
  - Stimulus: assert rst for 1 cycle while in DATA.
  - Required: next cycle grant = 00, busy = 0, and all valid/ready outputs are 0.
